// File: rtl/pl_inv_iter_pkg.sv
// Shared types and constants for the iterative inverse of the Ascon linear layer pL.
// Rotation tables hold (a_i * 2^k) mod 64 and (b_i * 2^k) mod 64 for row i, step k.
package pl_inv_iter_pkg;

  localparam int PL_INV_STEPS = 6;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_pl_inv_fsm;

  localparam logic [5:0] PL_ROT_A [0:4][0:5] = '{
    '{6'd19, 6'd38, 6'd12, 6'd24, 6'd48, 6'd32},
    '{6'd61, 6'd58, 6'd52, 6'd40, 6'd16, 6'd32},
    '{6'd1,  6'd2,  6'd4,  6'd8,  6'd16, 6'd32},
    '{6'd10, 6'd20, 6'd40, 6'd16, 6'd32, 6'd0 },
    '{6'd7,  6'd14, 6'd28, 6'd56, 6'd48, 6'd32}
  };

  localparam logic [5:0] PL_ROT_B [0:4][0:5] = '{
    '{6'd28, 6'd56, 6'd48, 6'd32, 6'd0,  6'd0 },
    '{6'd39, 6'd14, 6'd28, 6'd56, 6'd48, 6'd32},
    '{6'd6,  6'd12, 6'd24, 6'd48, 6'd32, 6'd0 },
    '{6'd17, 6'd34, 6'd4,  6'd8,  6'd16, 6'd32},
    '{6'd41, 6'd18, 6'd36, 6'd8,  6'd16, 6'd32}
  };

  // Some doubled amounts wrap to 0 mod 64; the double-width shift makes that an identity.
  function automatic logic [63:0] rotr64(input logic [63:0] v, input logic [5:0] r);
    logic [127:0] t;
    t = {v, v} >> r;
    return t[63:0];
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] v, input logic [5:0] ra,
                                        input logic [5:0] rb);
    return v ^ rotr64(v, ra) ^ rotr64(v, rb);
  endfunction

endpackage

// File: rtl/pl_inv_iter_step.sv
// One rotate-xor step of the pL inverse: row i gets x ^ ROTR(x, a_i*2^k) ^ ROTR(x, b_i*2^k).
// All amounts are constants selected by the step index, so no barrel shifter is built.
module pl_inv_step
  import pl_inv_iter_pkg::*;
(
  input  type_state  x,
  input  logic [2:0] k,
  output type_state  y
);

  // Per-row constant-rotation select on the step index
  always_comb begin
    y = '0;
    for (int i = 0; i < 5; i++) begin
      case (k)
        3'd0:    y[i] = sigma(x[i], PL_ROT_A[i][0], PL_ROT_B[i][0]);
        3'd1:    y[i] = sigma(x[i], PL_ROT_A[i][1], PL_ROT_B[i][1]);
        3'd2:    y[i] = sigma(x[i], PL_ROT_A[i][2], PL_ROT_B[i][2]);
        3'd3:    y[i] = sigma(x[i], PL_ROT_A[i][3], PL_ROT_B[i][3]);
        3'd4:    y[i] = sigma(x[i], PL_ROT_A[i][4], PL_ROT_B[i][4]);
        3'd5:    y[i] = sigma(x[i], PL_ROT_A[i][5], PL_ROT_B[i][5]);
        default: y[i] = x[i];
      endcase
    end
  end

endmodule

// File: rtl/pl_inv_iter.sv
// Iterative inverse of the Ascon pL layer: p^63 applied as six squared-polynomial steps
// on a registered 320-bit state, with valid/ready handshakes on both sides.
module pl_inv_iter
  import pl_inv_iter_pkg::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o
);

  localparam logic [2:0] LAST_STEP = 3'(PL_INV_STEPS - 1);

  type_pl_inv_fsm fsm_r;
  type_pl_inv_fsm fsm_next_s;
  logic [2:0]     cnt_r;
  logic [2:0]     cnt_next_s;
  type_state      work_r;
  type_state      work_next_s;
  type_state      step_s;

  pl_inv_step u_step (
    .x (work_r),
    .k (cnt_r),
    .y (step_s)
  );

  // Next-state, counter and working-register update
  always_comb begin
    fsm_next_s  = fsm_r;
    cnt_next_s  = cnt_r;
    work_next_s = work_r;
    case (fsm_r)
      IDLE: begin
        if (valid_i) begin
          fsm_next_s  = RUN;
          cnt_next_s  = 3'd0;
          work_next_s = state_i;
        end else begin
          fsm_next_s  = IDLE;
        end
      end
      RUN: begin
        work_next_s = step_s;
        if (cnt_r == LAST_STEP) begin
          fsm_next_s = DONE;
          cnt_next_s = cnt_r;
        end else begin
          fsm_next_s = RUN;
          cnt_next_s = cnt_r + 3'd1;
        end
      end
      DONE: begin
        if (ready_i) begin
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = DONE;
        end
      end
      default: begin
        fsm_next_s = IDLE;
        cnt_next_s = 3'd0;
      end
    endcase
  end

  // State, counter and working register with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_r  <= IDLE;
      cnt_r  <= 3'd0;
      work_r <= '0;
    end else begin
      fsm_r  <= fsm_next_s;
      cnt_r  <= cnt_next_s;
      work_r <= work_next_s;
    end
  end

  assign ready_o = (fsm_r == IDLE);
  assign valid_o = (fsm_r == DONE);
  assign state_o = work_r;

endmodule
